// File: rtl/pkt_switch_n.sv
// pkt_switch_n: one input byte stream routed to NUM_PORTS output queues.
// Each queue has a programmable address register. Headers that match no
// register send the packet to DROP, where it is counted in drop_cnt.
// The last byte of a packet (data_status low) is a parity byte. It is
// checked against the XOR of the header and the payload.
//
// Handshake: the source presents data/data_status. A byte is taken at a
// rising edge only when busy is low. While busy is high the source must
// hold data and data_status unchanged.
module pkt_switch_n #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        data_status,
  input  logic [DATA_W-1:0]           data,
  output logic                        busy,
  input  logic                        mem_en,
  input  logic                        mem_rd_wr,
  input  logic [IDX_W-1:0]            mem_add,
  input  logic [DATA_W-1:0]           mem_data,
  output logic [NUM_PORTS*DATA_W-1:0] port,
  output logic [NUM_PORTS-1:0]        ready,
  input  logic [NUM_PORTS-1:0]        read,
  output logic                        parity_err,
  output logic [7:0]                  drop_cnt,
  output logic [1:0]                  state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUTE = 2'd1, S_DROP = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_addr [NUM_PORTS];
  logic [IDX_W-1:0]    r_dest;
  logic [DATA_W-1:0]   r_acc;
  logic                r_perr;
  logic [7:0]          r_drop;

  logic [NUM_PORTS-1:0] w_full;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_busy, w_push, w_start, w_par_chk, w_drop_done;
  logic [IDX_W-1:0]     w_push_idx;

  // Address decode; scanning from the top down leaves the lowest match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (r_addr[i] == data) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic, backpressure and queue write control.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_push      = 1'b0;
    w_push_idx  = r_dest;
    w_start     = 1'b0;
    w_par_chk   = 1'b0;
    w_drop_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_status) begin
          if (w_hit) begin
            if (w_full[w_hit_idx]) begin
              w_busy = 1'b1;
            end else begin
              w_push      = 1'b1;
              w_push_idx  = w_hit_idx;
              w_start     = 1'b1;
              w_state_nxt = S_ROUTE;
            end
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_ROUTE: begin
        if (w_full[r_dest]) begin
          w_busy = 1'b1;
        end else begin
          w_push = 1'b1;
          if (!data_status) begin
            w_par_chk   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (!data_status) begin
          w_drop_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Packet context: latched destination, parity accumulator, error pulse, drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dest <= '0;
      r_acc  <= '0;
      r_perr <= 1'b0;
      r_drop <= '0;
    end else begin
      r_perr <= w_par_chk && (data != r_acc);
      if (w_start) begin
        r_dest <= w_hit_idx;
        r_acc  <= data;
      end else if (w_push && data_status) begin
        r_acc <= r_acc ^ data;
      end
      if (w_drop_done && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // Address registers. A write affects headers decoded from the next cycle on.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (reset) r_addr[i] <= DATA_W'(i);
      else if (mem_en && mem_rd_wr && (mem_add == IDX_W'(i))) r_addr[i] <= mem_data;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_q
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wp, r_rp;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_port;
    logic              w_push_q, w_pop_q;

    assign w_push_q = w_push && (w_push_idx == IDX_W'(g));
    assign w_pop_q  = read[g] && (r_cnt != '0);

    // Queue storage; no reset is needed because the pointers qualify the contents.
    always_ff @(posedge clk) begin
      if (w_push_q) r_mem[r_wp] <= data;
    end

    // Queue pointers, occupancy and the registered read port.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_port <= '0;
      end else begin
        if (w_push_q) r_wp <= r_wp + PTR_W'(1);
        if (w_pop_q) begin
          r_port <= r_mem[r_rp];
          r_rp   <= r_rp + PTR_W'(1);
        end
        if (w_push_q && !w_pop_q)      r_cnt <= r_cnt + CNT_W'(1);
        else if (!w_push_q && w_pop_q) r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    assign w_full[g]                   = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign ready[g]                    = (r_cnt != '0);
    assign port[g*DATA_W +: DATA_W]    = r_port;
  end

  assign busy       = w_busy;
  assign parity_err = r_perr;
  assign drop_cnt   = r_drop;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_pkt_switch_n.sv
// Testbench for pkt_switch_n (4 ports, 8-bit data, 16-deep queues).
// It runs a directed vector table plus hand-written sequences for the
// reset abort case and the full-queue backpressure case.
module tb_pkt_switch_n;

  logic        clk;
  logic        reset;
  logic        data_status;
  logic [7:0]  data;
  logic        busy;
  logic        mem_en;
  logic        mem_rd_wr;
  logic [1:0]  mem_add;
  logic [7:0]  mem_data;
  logic [31:0] port;
  logic [3:0]  ready;
  logic [3:0]  read;
  logic        parity_err;
  logic [7:0]  drop_cnt;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       cfg;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_val;
    logic       ds;
    logic [7:0] din;
    logic [3:0] rd;
    logic       exp_busy;
    logic [3:0] exp_ready;
    logic       exp_perr;
    logic [7:0] exp_drop;
    logic       chk_port;
    logic [1:0] port_idx;
    logic [7:0] exp_port;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  pkt_switch_n #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .data_status(data_status), .data(data), .busy(busy),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add), .mem_data(mem_data),
    .port(port), .ready(ready), .read(read), .parity_err(parity_err),
    .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] port_of(input int idx);
    return port[idx*8 +: 8];
  endfunction

  // Drive one cycle starting just after a rising edge. Busy is sampled before
  // the next edge, and the task returns 1 ns after that edge.
  task automatic step(input logic ds, input logic [7:0] d, input logic [3:0] rd, output logic b);
    data_status = ds;
    data        = d;
    read        = rd;
    #2;
    b = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic cfg, input logic [1:0] ci, input logic [7:0] cv,
                     input logic ds, input logic [7:0] din, input logic [3:0] rd,
                     input logic eb, input logic [3:0] er, input logic ep, input logic [7:0] ed,
                     input logic cp, input logic [1:0] pi, input logic [7:0] pv);
    vec_t v;
    v.cfg = cfg; v.cfg_idx = ci; v.cfg_val = cv; v.ds = ds; v.din = din; v.rd = rd;
    v.exp_busy = eb; v.exp_ready = er; v.exp_perr = ep; v.exp_drop = ed;
    v.chk_port = cp; v.port_idx = pi; v.exp_port = pv;
    vecs.push_back(v);
  endtask

  initial begin
    logic       b;
    logic       got_busy;
    logic       seen_perr;
    logic       rdy_before;
    int         idx;
    logic [7:0] pkt [20];
    logic [7:0] exp_b;

    reset = 1'b1; data_status = 1'b0; data = '0; read = '0;
    mem_en = 1'b0; mem_rd_wr = 1'b0; mem_add = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_port", port, 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    reset = 1'b0;

    // Reset in the middle of a payload aborts the packet cleanly.
    step(1'b1, 8'h01, 4'b0000, b);
    check("mid_hdr_busy", 32'(b), 32'h0);
    check("mid_hdr_ready", 32'(ready), 32'h2);
    step(1'b1, 8'hAA, 4'b0000, b);
    reset = 1'b1;
    step(1'b1, 8'hBB, 4'b0000, b);
    reset = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'h0);
    check("mid_rst_drop", 32'(drop_cnt), 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'h0);
    check("mid_rst_perr", 32'(parity_err), 32'h0);
    step(1'b0, 8'h00, 4'b0000, b);
    check("mid_rst_busy", 32'(b), 32'h0);
    step(1'b1, 8'h02, 4'b0000, b);
    step(1'b1, 8'h33, 4'b0000, b);
    step(1'b0, 8'h31, 4'b0000, b);
    check("fresh_ready", 32'(ready), 32'h4);
    check("fresh_perr", 32'(parity_err), 32'h0);
    step(1'b0, 8'h00, 4'b0100, b);
    check("fresh_p0", 32'(port_of(2)), 32'h02);
    step(1'b0, 8'h00, 4'b0100, b);
    check("fresh_p1", 32'(port_of(2)), 32'h33);
    step(1'b0, 8'h00, 4'b0100, b);
    check("fresh_p2", 32'(port_of(2)), 32'h31);
    check("fresh_empty", 32'(ready), 32'h0);

    // 20-byte packet to port 3: header, 18 payload bytes, parity.
    pkt[0] = 8'h03;
    for (int i = 1; i < 19; i++) pkt[i] = 8'h10 + 8'(i);
    pkt[19] = '0;
    for (int i = 0; i < 19; i++) pkt[19] = pkt[19] ^ pkt[i];
    idx = 0; got_busy = 1'b0; seen_perr = 1'b0;
    for (int cyc = 0; cyc < 40 && !got_busy; cyc++) begin
      step((idx < 19), pkt[idx], 4'b0000, b);
      if (parity_err) seen_perr = 1'b1;
      if (b) got_busy = 1'b1;
      else begin
        exp_q.push_back(pkt[idx]);
        idx++;
      end
    end
    check("full_busy_seen", 32'(got_busy), 32'h1);
    check("full_writes", 32'(idx), 32'd16);
    for (int cyc = 0; cyc < 100 && (idx < 20 || exp_q.size() > 0); cyc++) begin
      rdy_before = ready[3];
      if (idx < 20) step((idx < 19), pkt[idx], 4'b1000, b);
      else          step(1'b0, 8'h00, 4'b1000, b);
      if (parity_err) seen_perr = 1'b1;
      if (cyc == 0) check("full_busy_hold", 32'(b), 32'h1);
      if (cyc == 1) check("full_busy_drop", 32'(b), 32'h0);
      if (idx < 20 && !b) begin
        exp_q.push_back(pkt[idx]);
        idx++;
      end
      if (rdy_before) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL q3_extra actual=%0h expected=none", port_of(3));
        end else begin
          exp_b = exp_q.pop_front();
          check($sformatf("q3_byte_%0d", idx), 32'(port_of(3)), 32'(exp_b));
        end
      end
    end
    check("full_all_sent", 32'(idx), 32'd20);
    check("full_q_drained", 32'(exp_q.size()), 32'd0);
    check("full_ready_end", 32'(ready), 32'h0);
    check("full_no_perr", 32'(seen_perr), 32'h0);

    // Vector table.
    // Good packet to port 2; parity 02^11^22 = 31.
    add(0, 0, 8'h00, 1, 8'h02, 4'b0000, 0, 4'b0100, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h11, 4'b0000, 0, 4'b0100, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h22, 4'b0000, 0, 4'b0100, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h31, 4'b0000, 0, 4'b0100, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0100, 0, 4'b0100, 0, 8'd0, 1, 2, 8'h02);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0100, 0, 4'b0100, 0, 8'd0, 1, 2, 8'h11);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0100, 0, 4'b0100, 0, 8'd0, 1, 2, 8'h22);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0100, 0, 4'b0000, 0, 8'd0, 1, 2, 8'h31);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0100, 0, 4'b0000, 0, 8'd0, 1, 2, 8'h31);
    // Reprogram reg 1 to A5; bad parity (A5^01 = A4, sent 00).
    add(1, 1, 8'hA5, 0, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'hA5, 4'b0000, 0, 4'b0010, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h01, 4'b0000, 0, 4'b0010, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 4'b0010, 1, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 4'b0010, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0010, 0, 4'b0010, 0, 8'd0, 1, 1, 8'hA5);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0010, 0, 4'b0010, 0, 8'd0, 1, 1, 8'h01);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0010, 0, 4'b0000, 0, 8'd0, 1, 1, 8'h00);
    // Unknown header 77 is dropped; then a normal packet to port 0.
    add(0, 0, 8'h00, 1, 8'h77, 4'b0000, 0, 4'b0000, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h01, 4'b0000, 0, 4'b0000, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h02, 4'b0000, 0, 4'b0000, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h03, 4'b0000, 0, 4'b0000, 0, 8'd0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h04, 4'b0000, 0, 4'b0000, 0, 8'd1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h00, 4'b0000, 0, 4'b0001, 0, 8'd1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h5A, 4'b0000, 0, 4'b0001, 0, 8'd1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h5A, 4'b0000, 0, 4'b0001, 0, 8'd1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0001, 0, 4'b0001, 0, 8'd1, 1, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0001, 0, 4'b0001, 0, 8'd1, 1, 0, 8'h5A);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0001, 0, 4'b0000, 0, 8'd1, 1, 0, 8'h5A);
    // Regs 1 and 3 both hold 40; the lowest index (1) wins.
    add(1, 1, 8'h40, 0, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'd1, 0, 0, 8'h00);
    add(1, 3, 8'h40, 0, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'd1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 8'h40, 4'b0000, 0, 4'b0010, 0, 8'd1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h40, 4'b0000, 0, 4'b0010, 0, 8'd1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0010, 0, 4'b0010, 0, 8'd1, 1, 1, 8'h40);
    add(0, 0, 8'h00, 0, 8'h00, 4'b0010, 0, 4'b0000, 0, 8'd1, 1, 1, 8'h40);

    for (int i = 0; i < vecs.size(); i++) begin
      mem_en    = vecs[i].cfg;
      mem_rd_wr = vecs[i].cfg;
      mem_add   = vecs[i].cfg_idx;
      mem_data  = vecs[i].cfg_val;
      step(vecs[i].ds, vecs[i].din, vecs[i].rd, b);
      mem_en    = 1'b0;
      mem_rd_wr = 1'b0;
      check($sformatf("v%0d_busy", i), 32'(b), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
      check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
      if (vecs[i].chk_port)
        check($sformatf("v%0d_port%0d", i, vecs[i].port_idx),
              32'(port_of(int'(vecs[i].port_idx))), 32'(vecs[i].exp_port));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_switch_n.md
Name: pkt_switch_n

Overview:
- Parametrised successor of the 4-port packet switch: one input byte stream routed to NUM_PORTS output queues, each with a programmable address.
- Adds unknown-address drop, parity checking, FIFO backpressure and a drop counter.
- Sits between the packet source and per-port consumers. Synchronous-reset, single-clock generation of the switch.

Parameters:
- NUM_PORTS, 4, number of output ports/queues (2..16)
- DATA_W, 8, byte width of data, addresses and parity
- FIFO_DEPTH, 16, entries per output queue; power of 2, >=4
- IDX_W, $clog2(NUM_PORTS) (min 1), width of mem_add

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data_status  in  1  high for header+payload bytes; parity byte on first accepted cycle with it low
- data  in  DATA_W  input byte
- busy  out  1  input byte not accepted this cycle; source holds data/data_status
- mem_en  in  1  config access enable
- mem_rd_wr  in  1  1=write address register
- mem_add  in  IDX_W  port index to program
- mem_data  in  DATA_W  address value
- port  out  NUM_PORTS*DATA_W  per-port read data, port i at [i*DATA_W +: DATA_W]
- ready  out  NUM_PORTS  ready[i] = queue i not empty
- read  in  NUM_PORTS  pop request per port
- parity_err  out  1  one-cycle pulse on parity mismatch
- drop_cnt  out  8  saturating count of dropped packets

Behaviour:
- Clock/reset: one clock `clk`; reset is synchronous and active-high, sampled on the rising edge.
- Reset values: all queues emptied (pointers 0); port=0; ready=0; busy=0; parity_err=0; drop_cnt=0; FSM=IDLE; address register i = i.
- Reset mid-packet aborts the packet with no drop count and no error.
- Acceptance: a byte is accepted at a rising edge when busy=0. In IDLE, a cycle with data_status=0 carries no byte.
- Header decode (IDLE, data_status=1): compare data with all address registers; the lowest matching index wins.
  - Match and dest queue not full: write header to queue, latch dest index, init parity accumulator to the header, go to ROUTE.
  - Match and dest queue full: busy=1, stay in IDLE.
  - No match: accept header (busy=0), go to DROP.
- ROUTE:
  - data_status=1: write byte to dest, XOR it into the accumulator.
  - data_status=0: write parity byte to dest, compare with accumulator, set parity_err=1 next cycle if unequal, return to IDLE.
  - busy = dest queue full in ROUTE, combinational from registered state.
- DROP: bytes accepted and discarded, busy=0. On the data_status=0 (parity) byte, increment drop_cnt (saturating at 255) and return to IDLE.
- Config write: when mem_en & mem_rd_wr, the register updates at the edge. It affects only headers decoded from the next cycle on; an in-flight packet keeps its latched dest. mem_rd_wr=0 is a no-op.
- Queue i:
  - Circular buffer with pointer wrap at FIFO_DEPTH and an occupancy counter 0..FIFO_DEPTH.
  - read[i] while not empty: port slice i <= head entry next cycle (1-cycle latency), pointer advances.
  - read while empty: ignored, port holds its value.
  - Simultaneous push and pop on a non-empty queue: occupancy unchanged. A push into a full queue never occurs because busy blocks it.
  - A queue that is full at the edge accepts the pop; the push becomes eligible the following cycle.
- Throughput: 1 byte/cycle when not back-pressured. Header-to-ready latency is 1 cycle (ready rises the cycle after the header is written).

Test Plan:
- Reset, default addresses 0..3: send hdr 0x02, payload 0x11 0x22, parity 0x31 → queue2 holds 02 11 22 31; ready=4'b0100; parity_err stays 0; pulsing read[2] four times returns the bytes in order, one cycle after each read.
- Program addr reg 1=0xA5, then send hdr 0xA5, payload 0x01, bad parity 0x00 → bytes land in queue1; parity_err pulses once, 1 cycle after the parity byte.
- Send hdr 0x77 (no match) with 3 payload bytes + parity → no queue written; drop_cnt=1; next packet to port 0 routes normally.
- FIFO_DEPTH=16: send a 20-byte packet to port3 with no reads → busy rises after 16 writes; assert read[3] → busy drops; all 20 bytes arrive in order with none lost.
- Program two registers to 0x40 (idx 1 and 3), send hdr 0x40 → routed to port1 only.
- Assert reset in the middle of a payload → the next cycle shows all ready=0, busy=0, drop_cnt unchanged, FSM in IDLE; a fresh packet routes correctly.
